// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file port arbiter.
// Default widths match a 16 x 16-bit register file.
package rf_port_arbiter_pkg;

  localparam int RF_NUM_REGS     = 16;
  localparam int RF_DATA_W       = 16;
  localparam int RF_ADDR_W       = 4;
  localparam int RF_STARVE_LIMIT = 4;
  localparam int CNT_W           = 4;
  localparam int R0              = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Debug/host register-peek port: request channel plus valid/ready response channel.
// master = debug host side, slave = arbiter side.
interface rf_port_arbiter_if
  import rf_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
);

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_ready;
  logic              dbg_rsp_valid;
  logic [DATA_W-1:0] dbg_rsp_data;
  logic              dbg_rsp_ready;

  modport master (
    output dbg_req, dbg_addr, dbg_rsp_ready,
    input  dbg_ready, dbg_rsp_valid, dbg_rsp_data
  );

  modport slave (
    input  dbg_req, dbg_addr, dbg_rsp_ready,
    output dbg_ready, dbg_rsp_valid, dbg_rsp_data
  );

endinterface

// File: rtl/rf_port_arbiter_dec.sv
// Binary address to one-hot bit-cell enable decoder with a global enable.
module rf_addr_decoder
  import rf_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_addr] = 1'b1;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Register-file port scheduler: decodes pipeline enables and lends read port 2 to debug.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to readers.
//
// state   | meaning
// IDLE    | no debug transaction; debug granted when port 2 is idle
// WAIT    | debug pending behind pipeline port-2 reads; starvation counter running
// RESP    | captured debug data held until host takes it
module rf_port_arbiter
  import rf_port_arbiter_pkg::*;
#(
  parameter int NUM_REGS     = RF_NUM_REGS,
  parameter int DATA_W       = RF_DATA_W,
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_rd1_req,
  input  logic [ADDR_W-1:0]   i_rd1_addr,
  input  logic                i_rd2_req,
  input  logic [ADDR_W-1:0]   i_rd2_addr,
  output logic [DATA_W-1:0]   o_rd1_data,
  output logic [DATA_W-1:0]   o_rd2_data,
  output logic                o_pipe_stall,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_addr,
  input  logic [DATA_W-1:0]   i_wr_data,
  rf_port_arbiter_if.slave    dbg,
  output logic [NUM_REGS-1:0] o_rf_wen,
  output logic [DATA_W-1:0]   o_rf_wdata,
  output logic [NUM_REGS-1:0] o_rf_ren1,
  output logic [NUM_REGS-1:0] o_rf_ren2,
  input  logic [DATA_W-1:0]   i_rf_bl1,
  input  logic [DATA_W-1:0]   i_rf_bl2
);

  localparam logic [ADDR_W-1:0] L_R0    = ADDR_W'(R0);
  localparam logic [CNT_W-1:0]  L_LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt, w_starve_nxt;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_dbg_ready, w_pipe_stall, w_dbg_accept;
  logic              w_wr_valid, w_rd1_hit, w_rd2_hit, w_dbg_hit;
  logic              w_ren2_en;
  logic [ADDR_W-1:0] w_ren2_addr;
  logic [DATA_W-1:0] w_dbg_value;

  assign w_wr_valid = i_wr_en && (i_wr_addr != L_R0);

`ifdef RF_BYPASS_EN
  assign w_rd1_hit = w_wr_valid && (i_rd1_addr == i_wr_addr);
  assign w_rd2_hit = w_wr_valid && (i_rd2_addr == i_wr_addr);
  assign w_dbg_hit = w_wr_valid && (dbg.dbg_addr == i_wr_addr);
`else
  assign w_rd1_hit = 1'b0;
  assign w_rd2_hit = 1'b0;
  assign w_dbg_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    w_dbg_ready  = 1'b0;
    w_pipe_stall = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_dbg_ready = !i_rd2_req;
        if (dbg.dbg_req) begin
          if (!i_rd2_req) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt  = ST_WAIT;
            w_starve_nxt = CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (!dbg.dbg_req) begin
          w_state_nxt  = ST_IDLE;
          w_starve_nxt = '0;
        end else if (!i_rd2_req) begin
          w_dbg_ready  = 1'b1;
          w_state_nxt  = ST_RESP;
          w_starve_nxt = '0;
        end else if (r_starve_cnt == L_LIMIT) begin
          // pipeline has hogged port 2 long enough; stall it for one cycle
          w_dbg_ready  = 1'b1;
          w_pipe_stall = 1'b1;
          w_state_nxt  = ST_RESP;
          w_starve_nxt = '0;
        end else begin
          w_starve_nxt = r_starve_cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (dbg.dbg_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_starve_nxt = '0;
      end
    endcase
    if (i_rst) begin
      w_dbg_ready  = 1'b0;
      w_pipe_stall = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_dbg_accept) r_rsp_data <= w_dbg_value;
    end
  end

  assign w_dbg_accept = dbg.dbg_req && w_dbg_ready;
  assign w_ren2_en    = w_dbg_accept || i_rd2_req;
  assign w_ren2_addr  = w_dbg_accept ? dbg.dbg_addr : i_rd2_addr;
  assign w_dbg_value  = (dbg.dbg_addr == L_R0) ? '0 : (w_dbg_hit ? i_wr_data : i_rf_bl2);

  rf_addr_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_wr_dec (
    .i_en(w_wr_valid), .i_addr(i_wr_addr), .o_onehot(o_rf_wen)
  );

  rf_addr_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd1_dec (
    .i_en(i_rd1_req), .i_addr(i_rd1_addr), .o_onehot(o_rf_ren1)
  );

  rf_addr_decoder #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd2_dec (
    .i_en(w_ren2_en), .i_addr(w_ren2_addr), .o_onehot(o_rf_ren2)
  );

  // bitlines float whenever their port is unused, so gate them before they leave
  assign o_rd1_data = (!i_rd1_req || i_rd1_addr == L_R0) ? '0 :
                      (w_rd1_hit ? i_wr_data : i_rf_bl1);
  assign o_rd2_data = (!i_rd2_req || w_dbg_accept || i_rd2_addr == L_R0) ? '0 :
                      (w_rd2_hit ? i_wr_data : i_rf_bl2);

  assign o_rf_wdata        = i_wr_data;
  assign o_pipe_stall      = w_pipe_stall;
  assign dbg.dbg_ready     = w_dbg_ready;
  assign dbg.dbg_rsp_valid = (r_state == ST_RESP);
  assign dbg.dbg_rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Self-checking bench for rf_port_arbiter: bit-cell array model, reference register
// model and a debug-response scoreboard.
module tb_rf_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd1_req, rd2_req, wr_en;
  logic [3:0]  rd1_addr, rd2_addr, wr_addr;
  logic [15:0] wr_data, rd1_data, rd2_data;
  logic        pipe_stall;
  logic [15:0] rf_wen, rf_wdata, rf_ren1, rf_ren2, rf_bl1, rf_bl2;
  logic        cells_clr;

  logic [15:0] cells  [16];
  logic [15:0] ref_rf [16];
  logic [15:0] rsp_q  [$];

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] FLOAT_VAL = 16'h5A5A;

  rf_port_arbiter_if #(.ADDR_W(4), .DATA_W(16)) dbg_if ();

  rf_port_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd1_req(rd1_req), .i_rd1_addr(rd1_addr),
    .i_rd2_req(rd2_req), .i_rd2_addr(rd2_addr),
    .o_rd1_data(rd1_data), .o_rd2_data(rd2_data), .o_pipe_stall(pipe_stall),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .dbg(dbg_if.slave),
    .o_rf_wen(rf_wen), .o_rf_wdata(rf_wdata),
    .o_rf_ren1(rf_ren1), .o_rf_ren2(rf_ren2),
    .i_rf_bl1(rf_bl1), .i_rf_bl2(rf_bl2)
  );

  always #5 clk = ~clk;

  // bit-cell array; R0 cell deliberately holds junk so only DUT gating can zero it
  always @(posedge clk) begin
    if (cells_clr) begin
      for (int i = 0; i < 16; i++) cells[i] <= 16'h0;
      cells[0] <= 16'h0BAD;
    end else begin
      for (int i = 0; i < 16; i++) if (rf_wen[i]) cells[i] <= rf_wdata;
    end
  end

  always_comb begin
    rf_bl1 = (rf_ren1 == 16'h0) ? FLOAT_VAL : 16'h0;
    rf_bl2 = (rf_ren2 == 16'h0) ? FLOAT_VAL : 16'h0;
    for (int i = 0; i < 16; i++) begin
      if (rf_ren1[i]) rf_bl1 = rf_bl1 | cells[i];
      if (rf_ren2[i]) rf_bl2 = rf_bl2 | cells[i];
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] oh(input logic [3:0] a);
    logic [15:0] one;
    one = 16'h1;
    return one << a;
  endfunction

  always @(negedge clk) begin
    if (!rst && dbg_if.dbg_rsp_valid && dbg_if.dbg_rsp_ready) begin
      chk("rsp_expected", 16'(rsp_q.size() != 0), 16'd1);
      if (rsp_q.size() != 0) chk("rsp_data", dbg_if.dbg_rsp_data, rsp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
    if (a != 4'd0) ref_rf[a] = d;
  endtask

  // hold port 2 busy with a debug request pending; report cycle of the forced grant
  task automatic run_starve(input logic [3:0] a, output int stall_at);
    stall_at = -1;
    rd2_req = 1'b1; rd2_addr = 4'd2;
    dbg_if.dbg_req = 1'b1; dbg_if.dbg_addr = a;
    for (int c = 0; c < 20 && stall_at < 0; c++) begin
      #2;
      if (pipe_stall) begin
        stall_at = c;
        chk("stall_ready", 16'(dbg_if.dbg_ready), 16'd1);
        chk("stall_ren2", rf_ren2, oh(a));
        rsp_q.push_back(ref_rf[a]);
      end else begin
        chk("wait_ready", 16'(dbg_if.dbg_ready), 16'd0);
        chk("wait_rd2_data", rd2_data, ref_rf[2]);
      end
      step();
    end
    dbg_if.dbg_req = 1'b0;
  endtask

  task automatic finish_resp(input string tag);
    #2;
    chk({tag, "_stall_once"}, 16'(pipe_stall), 16'd0);
    chk({tag, "_valid"}, 16'(dbg_if.dbg_rsp_valid), 16'd1);
    chk({tag, "_rd2_pipe"}, rd2_data, ref_rf[2]);
    dbg_if.dbg_rsp_ready = 1'b1;
    step();
    dbg_if.dbg_rsp_ready = 1'b0;
    rd2_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_at;
    logic [15:0] exp_v;
    rst = 1'b1; cells_clr = 1'b1;
    rd1_req = 0; rd2_req = 0; wr_en = 0;
    rd1_addr = 0; rd2_addr = 0; wr_addr = 0; wr_data = 0;
    dbg_if.dbg_req = 0; dbg_if.dbg_addr = 0; dbg_if.dbg_rsp_ready = 0;
    for (int i = 0; i < 16; i++) ref_rf[i] = 16'h0;
    step(); step();
    #2;
    chk("rst_rsp_valid", 16'(dbg_if.dbg_rsp_valid), 16'd0);
    chk("rst_dbg_ready", 16'(dbg_if.dbg_ready), 16'd0);
    chk("rst_pipe_stall", 16'(pipe_stall), 16'd0);
    chk("rst_rsp_data", dbg_if.dbg_rsp_data, 16'h0);
    rst = 1'b0; cells_clr = 1'b0;
    step();

    // write R5 then read it on port 1
    wr_en = 1; wr_addr = 4'd5; wr_data = 16'hBEEF;
    #2;
    chk("wr5_wen", rf_wen, 16'h0020);
    chk("wr5_wdata", rf_wdata, 16'hBEEF);
    step(); wr_en = 0; ref_rf[5] = 16'hBEEF;
    rd1_req = 1; rd1_addr = 4'd5;
    #2;
    chk("rd1_r5_data", rd1_data, 16'hBEEF);
    chk("rd1_r5_ren", rf_ren1, 16'h0020);
    chk("rd2_idle_ren", rf_ren2, 16'h0000);

    // R0 is never written and always reads zero; idle port never leaks the bitline
    wr_en = 1; wr_addr = 4'd0; wr_data = 16'h1234; rd1_addr = 4'd0;
    #2;
    chk("wr0_wen", rf_wen, 16'h0000);
    chk("rd1_r0_data", rd1_data, 16'h0000);
    step(); wr_en = 0;
    rd1_req = 0; rd1_addr = 4'd5;
    #2;
    chk("rd1_off_ren", rf_ren1, 16'h0000);
    chk("rd1_off_data", rd1_data, 16'h0000);

    wr(4'd2, 16'h2222); wr(4'd3, 16'h3333); wr(4'd7, 16'h7777);

    // debug read with port 2 idle, response held under backpressure
    dbg_if.dbg_req = 1; dbg_if.dbg_addr = 4'd5;
    #2;
    chk("dbg_idle_ready", 16'(dbg_if.dbg_ready), 16'd1);
    chk("dbg_idle_ren2", rf_ren2, 16'h0020);
    chk("dbg_idle_stall", 16'(pipe_stall), 16'd0);
    rsp_q.push_back(ref_rf[5]);
    step(); dbg_if.dbg_req = 0;
    #2;
    chk("resp_valid", 16'(dbg_if.dbg_rsp_valid), 16'd1);
    chk("resp_data", dbg_if.dbg_rsp_data, 16'hBEEF);
    rd2_req = 1; rd2_addr = 4'd7;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("hold_valid", 16'(dbg_if.dbg_rsp_valid), 16'd1);
      chk("hold_data", dbg_if.dbg_rsp_data, 16'hBEEF);
      chk("hold_ready", 16'(dbg_if.dbg_ready), 16'd0);
      chk("hold_rd2_pipe", rd2_data, 16'h7777);
    end
    rd2_req = 0;
    dbg_if.dbg_rsp_ready = 1;
    step(); dbg_if.dbg_rsp_ready = 0;
    #2;
    chk("post_hs_valid", 16'(dbg_if.dbg_rsp_valid), 16'd0);
    chk("post_hs_ready", 16'(dbg_if.dbg_ready), 16'd1);

    // same-cycle write/read of R3 on port 1 and the debug path
`ifdef RF_BYPASS_EN
    exp_v = 16'hAAAA;
`else
    exp_v = 16'h3333;
`endif
    wr_en = 1; wr_addr = 4'd3; wr_data = 16'hAAAA; rd1_req = 1; rd1_addr = 4'd3;
    #2;
    chk("byp_rd1", rd1_data, exp_v);
    step(); ref_rf[3] = 16'hAAAA;
`ifdef RF_BYPASS_EN
    exp_v = 16'hBBBB;
`else
    exp_v = 16'hAAAA;
`endif
    wr_data = 16'hBBBB; dbg_if.dbg_req = 1; dbg_if.dbg_addr = 4'd3;
    #2;
    chk("byp_rd1_b", rd1_data, exp_v);
    rsp_q.push_back(exp_v);
    step(); ref_rf[3] = 16'hBBBB;
    wr_en = 0; rd1_req = 0; dbg_if.dbg_req = 0; dbg_if.dbg_rsp_ready = 1;
    #2;
    chk("byp_rsp_valid", 16'(dbg_if.dbg_rsp_valid), 16'd1);
    step(); dbg_if.dbg_rsp_ready = 0;

    // starvation: forced grant after four waiting cycles
    run_starve(4'd7, stall_at);
    chk("starve_cycle", 16'(stall_at), 16'd4);
    finish_resp("starve");

    // request withdrawn mid-wait must restart the starvation count
    rd2_req = 1; rd2_addr = 4'd2; dbg_if.dbg_req = 1; dbg_if.dbg_addr = 4'd7;
    step(); step();
    dbg_if.dbg_req = 0;
    #2;
    chk("drop_no_stall", 16'(pipe_stall), 16'd0);
    step();
    run_starve(4'd3, stall_at);
    chk("restart_cycle", 16'(stall_at), 16'd4);
    finish_resp("restart");

    // reset in RESP aborts the transaction
    dbg_if.dbg_req = 1; dbg_if.dbg_addr = 4'd5;
    step(); dbg_if.dbg_req = 0;
    #2;
    chk("abort_pre_valid", 16'(dbg_if.dbg_rsp_valid), 16'd1);
    rst = 1;
    step(); #2;
    chk("abort_valid", 16'(dbg_if.dbg_rsp_valid), 16'd0);
    chk("abort_ready", 16'(dbg_if.dbg_ready), 16'd0);
    rst = 0; dbg_if.dbg_rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("abort_no_stale", 16'(dbg_if.dbg_rsp_valid), 16'd0);
      chk("abort_idle_ready", 16'(dbg_if.dbg_ready), 16'd1);
    end
    dbg_if.dbg_rsp_ready = 0;
    step();

    chk("sb_drained", 16'(rsp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
